// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared types, widths and twiddle generator for the FFT sequencer.
// Revision : 1.0
// ============================================================================
package fft_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } fft_seq_state_t;

    localparam int     c_tw_frac     = 30;
    localparam longint c_half_pi_q30 = 64'sd1686629713;

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    function automatic int bin_width(input int n, input int w);
        return w + n;
    endfunction

    // cos/sin(2*pi*m/n) in Q30: quadrant reduction plus Taylor series, so
    // multiples of a quarter turn come out exact.
    function automatic logic signed [31:0] twiddle(input int m, input int n, input bit want_sin);
        longint q;
        longint r;
        longint a;
        longint c;
        longint s;
        longint term;
        longint c_out;
        longint s_out;
        int     mm;
        mm = m % n;
        q  = longint'((4 * mm) / n);
        r  = longint'(4 * mm) - q * longint'(n);
        a  = (c_half_pi_q30 * r) / longint'(n);
        c  = 0;
        s  = 0;
        term = longint'(1) <<< c_tw_frac;
        for (int i = 0; i < 12; i++) begin
            c    = c + term;
            term = -((((term * a) >>> c_tw_frac) * a) >>> c_tw_frac) / longint'((2*i+1) * (2*i+2));
        end
        term = a;
        for (int i = 0; i < 12; i++) begin
            s    = s + term;
            term = -((((term * a) >>> c_tw_frac) * a) >>> c_tw_frac) / longint'((2*i+2) * (2*i+3));
        end
        case (q)
            0:       begin c_out =  c; s_out =  s; end
            1:       begin c_out = -s; s_out =  c; end
            2:       begin c_out = -c; s_out = -s; end
            default: begin c_out =  s; s_out = -c; end
        endcase
        return want_sin ? 32'(s_out) : 32'(c_out);
    endfunction

endpackage
`default_nettype wire

// File: rtl/FFT.sv
`default_nettype none
// ============================================================================
// Module   : FFT
// Purpose  : Combinational N-point forward DFT core, Q.16 in, full-width out.
// Revision : 1.0
// ============================================================================
module FFT
    import fft_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 31
) (
    input  logic [N*(W+1)-1:0] x_re,
    input  logic [N*(W+1)-1:0] x_im,
    output logic [N*(W+N)-1:0] y_re,
    output logic [N*(W+N)-1:0] y_im
);

    localparam int c_bin_w = bin_width(N, W);
    localparam int c_idx_w = idx_width(N);
    localparam int c_acc_w = c_bin_w + c_tw_frac + 4;
    localparam logic signed [c_acc_w-1:0] c_round = c_acc_w'(1) <<< (c_tw_frac - 1);

    logic signed [W:0]  w_xr  [N];
    logic signed [W:0]  w_xi  [N];
    logic signed [31:0] w_cos [N];
    logic signed [31:0] w_sin [N];

    function automatic logic signed [c_acc_w-1:0] mul(input logic signed [W:0] a,
                                                      input logic signed [31:0] b);
        return c_acc_w'(a) * c_acc_w'(b);
    endfunction

    for (genvar m = 0; m < N; m++) begin : g_tw
        localparam logic signed [31:0] c_cos = twiddle(m, N, 1'b0);
        localparam logic signed [31:0] c_sin = twiddle(m, N, 1'b1);
        assign w_cos[m] = c_cos;
        assign w_sin[m] = c_sin;
        assign w_xr[m]  = x_re[m*(W+1) +: W+1];
        assign w_xi[m]  = x_im[m*(W+1) +: W+1];
    end

    // Products are summed at full precision and rounded once per bin.
    for (genvar k = 0; k < N; k++) begin : g_bin
        logic signed [c_acc_w-1:0] w_acc_re;
        logic signed [c_acc_w-1:0] w_acc_im;
        always_comb begin
            w_acc_re = '0;
            w_acc_im = '0;
            for (int n = 0; n < N; n++) begin
                w_acc_re = w_acc_re + mul(w_xr[n], w_cos[c_idx_w'((k*n) % N)])
                                    + mul(w_xi[n], w_sin[c_idx_w'((k*n) % N)]);
                w_acc_im = w_acc_im + mul(w_xi[n], w_cos[c_idx_w'((k*n) % N)])
                                    - mul(w_xr[n], w_sin[c_idx_w'((k*n) % N)]);
            end
        end
        assign y_re[k*c_bin_w +: c_bin_w] = c_bin_w'((w_acc_re + c_round) >>> c_tw_frac);
        assign y_im[k*c_bin_w +: c_bin_w] = c_bin_w'((w_acc_im + c_round) >>> c_tw_frac);
    end

endmodule
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sequencer
// Purpose  : Loads an N-sample frame, holds it on the FFT core, captures and
//            streams the bins. FFT_SETTLE_EN stretches COMPUTE by SETTLE cycles.
// Revision : 1.0
// ============================================================================
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int N      = 16,
    parameter int W      = 31,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W:0]           in_re,
    input  logic [W:0]           in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W+N-1:0]       out_re,
    output logic [W+N-1:0]       out_im,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 busy,
    output logic [15:0]          frame_cnt
);

    localparam int c_idx_w = idx_width(N);
    localparam int c_bin_w = bin_width(N, W);

    if (N < 4 || (N & (N - 1)) != 0 || SETTLE < 0) begin : g_param_check
        $error("fft_frame_sequencer: N must be a power of two >= 4, SETTLE >= 0");
    end

    fft_seq_state_t       r_state;
    fft_seq_state_t       w_state_nxt;
    logic [c_idx_w-1:0]   r_wr_ptr;
    logic [c_idx_w-1:0]   r_rd_ptr;
    logic [15:0]          r_frame_cnt;
    logic [W:0]           r_sbuf_re [N];
    logic [W:0]           r_sbuf_im [N];
    logic [c_bin_w-1:0]   r_cbuf_re [N];
    logic [c_bin_w-1:0]   r_cbuf_im [N];
    logic [N*(W+1)-1:0]   w_x_re;
    logic [N*(W+1)-1:0]   w_x_im;
    logic [N*c_bin_w-1:0] w_y_re;
    logic [N*c_bin_w-1:0] w_y_im;
    logic                 w_compute_done;
    logic                 w_wr_last;
    logic                 w_rd_last;

    for (genvar i = 0; i < N; i++) begin : g_flat
        assign w_x_re[i*(W+1) +: W+1] = r_sbuf_re[i];
        assign w_x_im[i*(W+1) +: W+1] = r_sbuf_im[i];
    end

    FFT #(.N(N), .W(W)) u_fft (
        .x_re (w_x_re),
        .x_im (w_x_im),
        .y_re (w_y_re),
        .y_im (w_y_im)
    );

`ifdef FFT_SETTLE_EN
    localparam int c_settle_w = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    logic [c_settle_w-1:0] r_settle_cnt;

    assign w_compute_done = (r_settle_cnt == c_settle_w'(SETTLE));

    always_ff @(posedge clk) begin
        if (rst || r_state != COMPUTE) begin
            r_settle_cnt <= '0;
        end else if (!w_compute_done) begin
            r_settle_cnt <= r_settle_cnt + c_settle_w'(1);
        end
    end
`else
    assign w_compute_done = 1'b1;
`endif

    assign w_wr_last = (r_wr_ptr == c_idx_w'(N - 1));
    assign w_rd_last = (r_rd_ptr == c_idx_w'(N - 1));

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && w_wr_last) w_state_nxt = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (w_compute_done) w_state_nxt = UNLOAD;
            end
            UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && w_rd_last) w_state_nxt = LOAD;
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == LOAD && in_valid) begin
                r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + c_idx_w'(1);
            end
            if (r_state == COMPUTE && w_compute_done) begin
                r_rd_ptr <= '0;
            end
            if (r_state == UNLOAD && out_ready) begin
                r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + c_idx_w'(1);
                if (w_rd_last) r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Sample storage carries no reset; only the pointer decides validity.
    always_ff @(posedge clk) begin
        if (!rst && r_state == LOAD && in_valid) begin
            r_sbuf_re[r_wr_ptr] <= in_re;
            r_sbuf_im[r_wr_ptr] <= in_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_cbuf_re[i] <= '0;
                r_cbuf_im[i] <= '0;
            end
        end else if (r_state == COMPUTE && w_compute_done) begin
            for (int i = 0; i < N; i++) begin
                r_cbuf_re[i] <= w_y_re[i*c_bin_w +: c_bin_w];
                r_cbuf_im[i] <= w_y_im[i*c_bin_w +: c_bin_w];
            end
        end
    end

    assign out_re    = r_cbuf_re[r_rd_ptr];
    assign out_im    = r_cbuf_im[r_rd_ptr];
    assign out_idx   = r_rd_ptr;
    assign out_last  = (r_state == UNLOAD) && w_rd_last;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_sequencer
// Purpose  : Self-checking bench; bins compared against a floating-point DFT.
// Revision : 1.0
// ============================================================================
module tb_fft_frame_sequencer;

    localparam int  N        = 16;
    localparam int  W        = 31;
    localparam int  SETTLE_P = 2;
    localparam int  BW       = W + N;
    localparam int  IW       = $clog2(N);
    localparam real PI       = 3.14159265358979323846;
`ifdef FFT_SETTLE_EN
    localparam int  EXP_LAT  = 2 + SETTLE_P;
`else
    localparam int  EXP_LAT  = 2;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [W:0]    in_re     = '0;
    logic [W:0]    in_im     = '0;
    logic          in_ready;
    logic          out_valid;
    logic [BW-1:0] out_re;
    logic [BW-1:0] out_im;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic [15:0]   frame_cnt;

    int     vectors     = 0;
    int     miscompares = 0;
    int     exp_frames  = 0;
    longint xr [N];
    longint xi [N];
    longint er [N];
    longint ei [N];
    longint got_re [N];
    longint got_im [N];

    fft_frame_sequencer #(.N(N), .W(W), .SETTLE(SETTLE_P)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp, input longint tol);
        logic signed [63:0] d;
        d = obs - exp;
        vectors++;
        assert ((tol == 0) ? (obs === exp) : ((d <= tol) && (d >= -tol))) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model();
        for (int k = 0; k < N; k++) begin
            real sr;
            real si;
            real th;
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                th = 2.0 * PI * real'((k * n) % N) / real'(N);
                sr += real'(xr[n]) * $cos(th) + real'(xi[n]) * $sin(th);
                si += real'(xi[n]) * $cos(th) - real'(xr[n]) * $sin(th);
            end
            er[k] = longint'(sr);
            ei[k] = longint'(si);
        end
    endtask

    task automatic load_ramp();
        for (int n = 0; n < N; n++) begin
            xr[n] = longint'(n) <<< 16;
            xi[n] = 0;
        end
        model();
    endtask

    task automatic load_impulse();
        for (int n = 0; n < N; n++) begin
            xr[n] = (n == 0) ? 65536 : 0;
            xi[n] = 0;
        end
        model();
    endtask

    task automatic load_random();
        for (int n = 0; n < N; n++) begin
            xr[n] = longint'($urandom_range(0, 33554432)) - 16777216;
            xi[n] = longint'($urandom_range(0, 33554432)) - 16777216;
        end
        model();
    endtask

    task automatic send_frame(input bit gaps, input int count);
        int i = 0;
        int guard = 0;
        out_ready = 1'b0;
        while (i < count && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_re    = $urandom;
                in_im    = $urandom;
            end else begin
                chk("load_in_ready", 64'(in_ready), 1, 0);
                in_valid = 1'b1;
                in_re    = xr[i][W:0];
                in_im    = xi[i][W:0];
                i++;
            end
        end
    endtask

    task automatic wait_latency();
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("compute_busy", 64'(busy), 1, 0);
                chk("compute_in_ready", 64'(in_ready), 0, 0);
            end
            in_valid = 1'b1;
            in_re    = $urandom;
            in_im    = $urandom;
        end while (out_valid !== 1'b1 && lat < 50);
        chk("latency", 64'(lat), 64'(EXP_LAT), 0);
    endtask

    task automatic recv_frame(input bit stalls, input int stop_at);
        int            cnt = 0;
        int            guard = 0;
        bit            held = 1'b0;
        logic [BW-1:0] p_re;
        logic [BW-1:0] p_im;
        logic [IW-1:0] p_idx;
        while (cnt < stop_at && guard < 4000) begin
            in_valid = 1'b1;
            in_re    = $urandom;
            in_im    = $urandom;
            if (held) begin
                chk("stall_valid", 64'(out_valid), 1, 0);
                chk("stall_re", 64'($signed(out_re)), 64'($signed(p_re)), 0);
                chk("stall_im", 64'($signed(out_im)), 64'($signed(p_im)), 0);
                chk("stall_idx", 64'(out_idx), 64'(p_idx), 0);
            end
            if (out_valid === 1'b1) begin
                chk("unload_in_ready", 64'(in_ready), 0, 0);
                out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (out_ready) begin
                    got_re[cnt] = longint'($signed(out_re));
                    got_im[cnt] = longint'($signed(out_im));
                    chk("bin_idx", 64'(out_idx), 64'(cnt), 0);
                    chk("bin_last", 64'(out_last), (cnt == N - 1) ? 1 : 0, 0);
                    chk("bin_re", 64'($signed(out_re)), er[cnt], 2);
                    chk("bin_im", 64'($signed(out_im)), ei[cnt], 2);
                    cnt++;
                    held = 1'b0;
                end else begin
                    held  = 1'b1;
                    p_re  = out_re;
                    p_im  = out_im;
                    p_idx = out_idx;
                end
            end else begin
                out_ready = 1'b0;
                held      = 1'b0;
            end
            guard++;
            if (cnt < stop_at) @(negedge clk);
        end
        if (cnt < stop_at) chk("unload_timeout", 64'(cnt), 64'(stop_at), 0);
    endtask

    task automatic frame_done();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_frames++;
        chk("done_in_ready", 64'(in_ready), 1, 0);
        chk("done_out_valid", 64'(out_valid), 0, 0);
        chk("done_busy", 64'(busy), 0, 0);
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames), 0);
    endtask

    task automatic run_frame(input bit gaps, input bit stalls);
        send_frame(gaps, N);
        wait_latency();
        recv_frame(stalls, N);
        frame_done();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 0, 0);
        chk("rst_in_ready", 64'(in_ready), 1, 0);
        chk("rst_frame_cnt", 64'(frame_cnt), 0, 0);
        chk("rst_busy", 64'(busy), 0, 0);
        chk("rst_out_last", 64'(out_last), 0, 0);
        rst        = 1'b0;
        exp_frames = 0;
    endtask

    task automatic check_ramp_bins();
        chk("ramp_bin0_re", got_re[0], 7864320, 0);
        chk("ramp_bin0_im", got_im[0], 0, 0);
        chk("ramp_bin8_re", got_re[8], -524288, 0);
        chk("ramp_bin8_im", got_im[8], 0, 0);
        chk("ramp_bin1_re", got_re[1], -524288, 2);
        chk("ramp_bin1_im", got_im[1], 2635774, 2);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 1, 0);
        chk("rst_out_valid", 64'(out_valid), 0, 0);
        chk("rst_out_last", 64'(out_last), 0, 0);
        chk("rst_out_idx", 64'(out_idx), 0, 0);
        chk("rst_busy", 64'(busy), 0, 0);
        chk("rst_frame_cnt", 64'(frame_cnt), 0, 0);
        chk("rst_out_re", 64'($signed(out_re)), 0, 0);
        chk("rst_out_im", 64'($signed(out_im)), 0, 0);
        rst = 1'b0;

        load_ramp();
        run_frame(1'b0, 1'b0);
        check_ramp_bins();

        for (int f = 0; f < 3; f++) begin
            load_random();
            run_frame(1'b1, 1'b1);
        end

        do_reset();
        load_impulse();
        run_frame(1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            chk("imp_re", got_re[k], 65536, 0);
            chk("imp_im", got_im[k], 0, 0);
        end
        load_random();
        run_frame(1'b0, 1'b0);

        load_ramp();
        send_frame(1'b0, 7);
        do_reset();

        load_ramp();
        send_frame(1'b0, N);
        wait_latency();
        recv_frame(1'b0, 5);
        @(negedge clk);
        out_ready = 1'b0;
        chk("pre_rst_idx", 64'(out_idx), 5, 0);
        do_reset();

        load_ramp();
        run_frame(1'b1, 1'b0);
        check_ramp_bins();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
